cpu_control_fsm: RTL
====================

# cpu_control_fsm

Multi-cycle control unit for the 16-bit CR16-style datapath. Fetches one instruction word per instruction from unified memory, holds it in an instruction register, and sequences the register file, ALU operand muxes, memory and PC. It sits directly upstream of the register file and drives its write enable and flag capture. Operand addresses, immediate and condition fields come from the exported `ir`.

## Interface
- `DATA_WIDTH`, 16: instruction/data word width. Only 16 is supported.
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `mem_rd_data`  in  16  memory read data, valid one cycle after address is presented (synchronous-read RAM)
- `C`, `L`, `F`, `Z`, `N`  in  1 each  current flags from the register file
- `ir`  out  16  instruction register: `[15:12]` opcode, `[11:8]` Rdest/cond, `[7:4]` ext, `[3:0]` Rsrc/Raddr
- `rf_wr_en`  out  1  write Rdest (`ir[11:8]`)
- `flag_wr_en`  out  1  capture ALU flags
- `wb_sel`  out  2  write-back source: 0 ALU, 1 memory, 2 PC+1 (link)
- `imm_sel`  out  1  ALU B operand: 0 Rsrc, 1 immediate `ir[7:0]`
- `addr_sel`  out  1  memory address: 0 PC, 1 register `ir[3:0]`
- `mem_wr_en`  out  1  store Rdest-port data to memory
- `pc_en`  out  1  update PC this edge
- `pc_sel`  out  2  next PC: 0 PC+1, 1 PC+sext(`ir[7:0]`), 2 register `ir[3:0]`

## Operation
- States: FETCH, LATCH, EXEC, LOAD_WB.
- FETCH: `addr_sel`=0. Go to LATCH.
- LATCH: `ir` <= `mem_rd_data`. Go to EXEC.
- EXEC decodes `ir`:
  - Opcode 0100: ext 0000 LOAD goes to LOAD_WB with `addr_sel`=1. ext 0100 STOR asserts `mem_wr_en`, `addr_sel`=1, `pc_en`. ext 1000 JAL asserts `rf_wr_en`, `wb_sel`=2, `pc_en`, `pc_sel`=2. ext 1100 Jcond asserts `pc_en`, with `pc_sel`=2 if cond true else 0. Any other ext is a NOP that only asserts `pc_en`.
  - Opcode 1100 (Bcond): `pc_en`, with `pc_sel`=1 if cond true else 0.
  - Otherwise it is ALU class. key = ext when opcode=0000, else opcode; `imm_sel` = (opcode≠0000).
    - key 0000: NOP.
    - key 1011 (CMP/CMPI): `flag_wr_en` only.
    - Any other key: `rf_wr_en` with `wb_sel`=0.
    - `flag_wr_en` is also asserted for key 0101 (ADD) and 1001 (SUB).
    - Every ALU-class instruction asserts `pc_en` with `pc_sel`=0.
  - EXEC returns to FETCH except for LOAD.
- LOAD_WB: `rf_wr_en`, `wb_sel`=1, `addr_sel`=1, `pc_en`, `pc_sel`=0. Go to FETCH.
- Condition is `ir[11:8]`:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 HI: L. 0101 LS: !L.
  - 0110 GT: N. 0111 LE: !N.
  - 1000 FS: F. 1001 FC: !F.
  - 1010 LO: !L&!Z. 1011 HS: L|Z.
  - 1100 LT: !N&!Z. 1101 GE: N|Z.
  - 1110 UC: 1. 1111: never.
- Outputs are a pure function of state, `ir` and flags. Any select or enable not listed for a state is 0.

## Timing
- Reset: state=FETCH and `ir`=0 on the edge where `reset` is high. While `reset` is high, all enables (`rf_wr_en`, `flag_wr_en`, `mem_wr_en`, `pc_en`) are forced to 0 combinationally.
- Reset mid-instruction: the instruction is abandoned with no write, and FETCH starts the cycle after `reset` falls.
- Latency: 3 cycles per instruction, 4 for LOAD. There are no stalls.
- At most one write (`rf_wr_en`/`mem_wr_en`) occurs per instruction.
- Flags are sampled in EXEC. A CMP followed by Bcond sees the updated flags, because the flags are captured at the end of the CMP EXEC cycle.
- An unknown state decodes to FETCH with all enables 0.

## Structure
- Shared package `cpu_defs_pkg` holds:
  - the state enum;
  - opcode/ext constants (LOAD, STOR, JAL, JCOND, BCOND, CMP, ADD, SUB);
  - condition codes 0000–1111;
  - the `wb_sel`/`pc_sel`/`addr_sel` encodings.
- Sub-module `cond_eval`: combinational, 4-bit cond plus C, L, F, Z, N in, 1-bit take out.

## Test plan
- Reset held 3 cycles then released with `mem_rd_data`=16'h0000: enables are 0 during reset. After release, FETCH→LATCH→EXEC, with `pc_en`=1 and `pc_sel`=0 in EXEC and no `rf_wr_en`.
- ADDI 16'h5305: `ir`=16'h5305 in EXEC with `rf_wr_en`, `flag_wr_en`, `imm_sel`=1 and `wb_sel`=0. The next cycle is FETCH.
- LOAD 16'h4201: EXEC has `addr_sel`=1 and no writes. LOAD_WB has `rf_wr_en`, `wb_sel`=1 and `pc_en`. Total 4 cycles.
- BEQ 16'hC0FE with Z=1: `pc_sel`=1. With Z=0: `pc_sel`=0. Repeat for all 16 conditions against exhaustive flag vectors.
- JAL 16'h4E83: `rf_wr_en`, `wb_sel`=2, `pc_sel`=2. Assert `reset` during EXEC of STOR 16'h4541: `mem_wr_en` stays 0 and the state is FETCH next cycle.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the CR16-style control unit: FSM states, opcode/ext
// keys, condition codes and datapath mux encodings.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    StFetch  = 2'd0,
    StLatch  = 2'd1,
    StExec   = 2'd2,
    StLoadWb = 2'd3
  } state_e;

  localparam logic [3:0] OpRtype  = 4'b0000;
  localparam logic [3:0] OpMem    = 4'b0100;
  localparam logic [3:0] OpBcond  = 4'b1100;

  localparam logic [3:0] ExtLoad  = 4'b0000;
  localparam logic [3:0] ExtStor  = 4'b0100;
  localparam logic [3:0] ExtJal   = 4'b1000;
  localparam logic [3:0] ExtJcond = 4'b1100;

  localparam logic [3:0] KeyNop   = 4'b0000;
  localparam logic [3:0] KeyAdd   = 4'b0101;
  localparam logic [3:0] KeySub   = 4'b1001;
  localparam logic [3:0] KeyCmp   = 4'b1011;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondHi = 4'b0100;
  localparam logic [3:0] CondLs = 4'b0101;
  localparam logic [3:0] CondGt = 4'b0110;
  localparam logic [3:0] CondLe = 4'b0111;
  localparam logic [3:0] CondFs = 4'b1000;
  localparam logic [3:0] CondFc = 4'b1001;
  localparam logic [3:0] CondLo = 4'b1010;
  localparam logic [3:0] CondHs = 4'b1011;
  localparam logic [3:0] CondLt = 4'b1100;
  localparam logic [3:0] CondGe = 4'b1101;
  localparam logic [3:0] CondUc = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbMem  = 2'd1;
  localparam logic [1:0] WbLink = 2'd2;

  localparam logic [1:0] PcInc  = 2'd0;
  localparam logic [1:0] PcRel  = 2'd1;
  localparam logic [1:0] PcReg  = 2'd2;

  localparam logic AddrPc  = 1'b0;
  localparam logic AddrReg = 1'b1;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control-unit bundle: memory read data and flags in, instruction register and
// datapath controls out.
interface cpu_control_fsm_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  C, L, F, Z, N;
  logic [DATA_WIDTH-1:0] ir;
  logic                  rf_wr_en;
  logic                  flag_wr_en;
  logic [1:0]            wb_sel;
  logic                  imm_sel;
  logic                  addr_sel;
  logic                  mem_wr_en;
  logic                  pc_en;
  logic [1:0]            pc_sel;

  modport master (
    input  mem_rd_data, C, L, F, Z, N,
    output ir, rf_wr_en, flag_wr_en, wb_sel, imm_sel, addr_sel, mem_wr_en, pc_en, pc_sel
  );

  modport slave (
    output mem_rd_data, C, L, F, Z, N,
    input  ir, rf_wr_en, flag_wr_en, wb_sel, imm_sel, addr_sel, mem_wr_en, pc_en, pc_sel
  );
endinterface

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the
// current flags to a take decision.
module cond_eval
  import cpu_defs_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       C,
  input  logic       L,
  input  logic       F,
  input  logic       Z,
  input  logic       N,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    unique case (cond)
      CondEq: take = Z;
      CondNe: take = ~Z;
      CondCs: take = C;
      CondCc: take = ~C;
      CondHi: take = L;
      CondLs: take = ~L;
      CondGt: take = N;
      CondLe: take = ~N;
      CondFs: take = F;
      CondFc: take = ~F;
      CondLo: take = ~L & ~Z;
      CondHs: take = L | Z;
      CondLt: take = ~N & ~Z;
      CondGe: take = N | Z;
      CondUc: take = 1'b1;
      CondNv: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control FSM: fetch, latch IR, execute, optional load write-back.
// Outputs are decoded from state, IR and flags; reset masks all enables.
module cpu_control_fsm
  import cpu_defs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  cpu_control_fsm_if.master  bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [3:0]            opcode, cond, ext, key;
  logic                  take;

  logic       rf_wr, flag_wr, imm, addr, mem_wr, pc_upd;
  logic [1:0] wb, pc_nxt;

  assign opcode = ir_q[15:12];
  assign cond   = ir_q[11:8];
  assign ext    = ir_q[7:4];
  // Register-form ALU ops carry their function in ext; immediate forms in opcode.
  assign key    = (opcode == OpRtype) ? ext : opcode;

  cond_eval u_cond_eval (
    .cond (cond),
    .C    (bus.C),
    .L    (bus.L),
    .F    (bus.F),
    .Z    (bus.Z),
    .N    (bus.N),
    .take (take)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    ir_d    = ir_q;
    case (state_q)
      StFetch: state_d = StLatch;
      StLatch: begin
        ir_d    = bus.mem_rd_data;
        state_d = StExec;
      end
      StExec: begin
        if (opcode == OpMem && ext == ExtLoad) state_d = StLoadWb;
      end
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    rf_wr   = 1'b0;
    flag_wr = 1'b0;
    wb      = WbAlu;
    imm     = 1'b0;
    addr    = AddrPc;
    mem_wr  = 1'b0;
    pc_upd  = 1'b0;
    pc_nxt  = PcInc;
    case (state_q)
      StExec: begin
        if (opcode == OpMem) begin
          case (ext)
            ExtLoad: addr = AddrReg;
            ExtStor: begin
              mem_wr = 1'b1;
              addr   = AddrReg;
              pc_upd = 1'b1;
            end
            ExtJal: begin
              rf_wr  = 1'b1;
              wb     = WbLink;
              pc_upd = 1'b1;
              pc_nxt = PcReg;
            end
            ExtJcond: begin
              pc_upd = 1'b1;
              pc_nxt = take ? PcReg : PcInc;
            end
            default: pc_upd = 1'b1;
          endcase
        end else if (opcode == OpBcond) begin
          pc_upd = 1'b1;
          pc_nxt = take ? PcRel : PcInc;
        end else begin
          imm    = (opcode != OpRtype);
          pc_upd = 1'b1;
          if (key == KeyCmp) begin
            flag_wr = 1'b1;
          end else if (key != KeyNop) begin
            rf_wr   = 1'b1;
            flag_wr = (key == KeyAdd) || (key == KeySub);
          end
        end
      end
      StLoadWb: begin
        rf_wr  = 1'b1;
        wb     = WbMem;
        addr   = AddrReg;
        pc_upd = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ir         = ir_q;
  assign bus.rf_wr_en   = rf_wr & ~reset;
  assign bus.flag_wr_en = flag_wr & ~reset;
  assign bus.mem_wr_en  = mem_wr & ~reset;
  assign bus.pc_en      = pc_upd & ~reset;
  assign bus.wb_sel     = wb;
  assign bus.imm_sel    = imm;
  assign bus.addr_sel   = addr;
  assign bus.pc_sel     = pc_nxt;

endmodule
